// File: rtl/alu_share_arbiter.sv
// Round-robin time-sharing of one combinational ALU between the execute stage (0)
// and the address/branch-compare unit (1); operands and results are registered.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [3:0]       alu_cntrl,
    input  logic [WIDTH-1:0] alu_dout
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state, state_nxt;
    logic   last_grant;
    logic   owner;
    logic   grant;
    logic   any_valid;
    logic   rsp_valid_q;
    logic   rsp_fire;
    logic   op_legal;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110,
            4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1100: is_legal = 1'b1;
            default:                                     is_legal = 1'b0;
        endcase
    endfunction

    assign any_valid = req0_valid | req1_valid;
    // On a tie the requester not served last wins; otherwise the lone requester.
    assign grant     = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    assign op_legal  = is_legal(alu_cntrl);
    assign rsp_fire  = rsp_valid_q & (owner ? rsp1_ready : rsp0_ready);
    assign rsp0_valid = rsp_valid_q & ~owner;
    assign rsp1_valid = rsp_valid_q & owner;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_nxt  = EXEC;
                    // Gated by rst_n so readys read low for the whole reset pulse.
                    req0_ready = rst_n & ~grant;
                    req1_ready = rst_n & grant;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state and datapath registers use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            alu_in1     <= '0;
            alu_in2     <= '0;
            alu_cntrl   <= 4'b0000;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        owner     <= grant;
                        alu_in1   <= grant ? req1_a  : req0_a;
                        alu_in2   <= grant ? req1_b  : req0_b;
                        alu_cntrl <= grant ? req1_op : req0_op;
                    end
                end
                EXEC: begin
                    rsp_err  <= ~op_legal;
                    rsp_data <= op_legal ? alu_dout : '0;
                end
                RESP: begin
                    // Valid rises one cycle into RESP and drops on the owner's handshake.
                    if (rsp_fire) begin
                        rsp_valid_q <= 1'b0;
                        last_grant  <= owner;
                    end else begin
                        rsp_valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Time-shares the single combinational ALU between two independent requesters: requester 0 is the execute stage and requester 1 is the address/branch-compare unit. The block arbitrates round-robin, captures the winning operands and opcode, and drives the ALU from registers. It then registers the ALU result and returns it to the winner over a valid/ready response channel. It sits between the requesters and the ALU instance; the ALU itself is unchanged.

## Interface
- WIDTH, 32, operand/result width; must match the ALU data width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle; a transfer occurs when valid && ready.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands (ALU in1, in2).
- req0_op / req1_op  in  4  ALU control code.
- rsp0_valid / rsp1_valid  out  1  result available.
- rsp0_ready / rsp1_ready  in  1  requester consumes the result.
- rsp_data  out  WIDTH  result, shared by both response channels.
- rsp_err  out  1  the op was illegal; rsp_data is forced to 0.
- alu_in1, alu_in2  out  WIDTH  to ALU in1/in2, registered.
- alu_cntrl  out  4  to ALU alucntrl, registered.
- alu_dout  in  WIDTH  from ALU dout.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. If exactly one reqN_valid is high, that requester wins.
  - If both are high, the requester not served last wins. The last_grant register resets to 1, so requester 0 wins the first tie.
  - reqN_ready is high only in IDLE and only for the granted requester. With no valid request, both readys are low.
  - On transfer: capture a into alu_in1, b into alu_in2, op into alu_cntrl, and the winner id into owner. Then move to EXEC.
- EXEC (exactly 1 cycle):
  - Latch alu_dout into rsp_data.
  - If alu_cntrl is not in {0000, 0001, 0010, 0011, 0110, 0111, 1000, 1001, 1010, 1100}, latch 0 and set rsp_err = 1. Otherwise set rsp_err = 0.
  - Move to RESP.
- RESP:
  - rsp<owner>_valid = 1. The other rspN_valid = 0.
  - rsp_data and rsp_err are held stable.
  - On rsp<owner>_ready: set last_grant = owner and return to IDLE.
  - Readys are low throughout, so a new request waits.
- The ALU operand and control registers hold their last values outside IDLE captures; they never change in EXEC or RESP.
- rsp<other>_ready is ignored.
- Both readys are low outside IDLE, so requests asserted during EXEC/RESP stall. Requesters must hold a, b and op stable while valid && !ready.

## Timing
- Reset (asynchronous, rst_n low):
  - state = IDLE, last_grant = 1, owner = 0.
  - alu_in1 = alu_in2 = 0, alu_cntrl = 0000.
  - rsp_data = 0, rsp_err = 0.
  - All readys and rsp valids = 0.
- Latency, with accept at edge T:
  - EXEC occupies cycle T+1.
  - rsp_valid is high from the cycle after edge T+2.
  - With rsp_ready already high, the response completes at edge T+3 and the next accept can occur at edge T+4.
  - Minimum period is 4 cycles per operation.
- Response hold: rsp_valid stays high indefinitely until ready; rsp_data is unchanged while held.
- Reset mid-operation (EXEC or RESP): the in-flight result is discarded, all outputs go to reset values immediately, and no response is issued after reset releases.
- Simultaneous events: a single requester is never starved. With both valid continuously, grants alternate 0, 1, 0, 1, ...
- Single requester back-to-back: repeated grants to the same requester are allowed when the other is idle.

## Test plan
- Reset, then req0 ADD (op 0010) with a = 5, b = 7; rsp0_ready held high -> req0_ready pulses one cycle, rsp0_valid two cycles later with rsp_data = 12, rsp_err = 0; rsp1_valid stays 0.
- req0 and req1 both valid continuously: req0 SUB 10 − 3, req1 SLT 2 < 9 -> grant order 0, 1, 0, 1; responses 7 and 1 respectively; each accept is 4 cycles apart.
- req1 SRA (op 1010) with a = 0x8000_0000, b = 4; rsp1_ready held low for 5 cycles, then high -> rsp1_valid and rsp_data = 0x0800_0000 stable all 5 cycles (ALU `>>>` on the unsigned operand acts logically); req0 valid during the hold sees ready = 0 until after completion.
- req0 illegal op 0100 with a = 1, b = 1 -> rsp_data = 0, rsp_err = 1; the next legal op AND 0xF0 & 0x3C returns 0x30 with rsp_err = 0.
- Assert rst_n low during EXEC of req1 OR 0x1 | 0x2 -> all outputs go to zero immediately; after release, no rsp1_valid appears, the FSM is in IDLE, and a tie goes to requester 0.
- req0 only, three back-to-back XORs (0xFF ^ 0x0F, 0 ^ 0, 0xAAAA ^ 0x5555) -> results 0xF0, 0, 0xFFFF in order, with no lost or duplicated responses.
